// File: rtl/spidergon_packetizer.sv
// Spidergon network-interface transmitter.
// Turns a CPU packet request plus a stream of payload words into head, body
// and tail flits for the local node's injection port. Flow control is ON/OFF:
// a head waits for per-VC ready and not-full, body and tail wait on not-full only.
module spidergon_packetizer #(
    parameter  int NUM_OF_NODES            = 8,
    parameter  int FLIT_DATA_WIDTH         = 16,
    parameter  int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter  int NODE_IDENTIFIER         = 0,
    parameter  int MAX_BODY_FLITS          = 4,
    localparam int DEST_NODE_WIDTH         = $clog2(NUM_OF_NODES),
    localparam int FLIT_TOTAL_WIDTH        = FLIT_DATA_WIDTH + 2,
    localparam int VC_ID_WIDTH             = $clog2(NUM_OF_VIRTUAL_CHANNELS),
    localparam int LEN_WIDTH               = $clog2(MAX_BODY_FLITS + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pkt_req_valid,
    output logic                               pkt_req_ready,
    input  logic [DEST_NODE_WIDTH-1:0]         pkt_dest,
    input  logic [VC_ID_WIDTH-1:0]             pkt_vc,
    input  logic [LEN_WIDTH-1:0]               pkt_num_body,
    input  logic                               payload_valid,
    input  logic [FLIT_DATA_WIDTH-1:0]         payload_data,
    output logic                               payload_ready,
    output logic [FLIT_TOTAL_WIDTH-1:0]        flit_data_output,
    output logic                               flit_data_output_is_valid,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] adjacent_node_is_ready,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] adjacent_node_vc_is_full,
    output logic                               packet_sent,
    output logic                               pkt_error
);

    // Head flit fields packed MSB-first below the two type bits.
    localparam int HEAD_FIELDS_WIDTH = VC_ID_WIDTH + 2 * DEST_NODE_WIDTH;

    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_BODY   = 2'b10;
    localparam logic [1:0] TYPE_TAIL   = 2'b00;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    localparam logic [DEST_NODE_WIDTH-1:0] SOURCE_ID = DEST_NODE_WIDTH'(NODE_IDENTIFIER);
    localparam logic [LEN_WIDTH-1:0]       MAX_LEN   = LEN_WIDTH'(MAX_BODY_FLITS);
    localparam logic [LEN_WIDTH-1:0]       ONE_LEN   = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_nextState;
    logic [DEST_NODE_WIDTH-1:0]   r_dest;
    logic [VC_ID_WIDTH-1:0]       r_vc;
    logic [LEN_WIDTH-1:0]         r_remaining;
    logic [FLIT_TOTAL_WIDTH-1:0]  r_flit;
    logic                         r_flitValid;
    logic                         r_packetSent;
    logic                         r_pktError;

    logic                         w_emit;
    logic [FLIT_TOTAL_WIDTH-1:0]  w_flit;
    logic                         w_packetSent;
    logic                         w_pktError;
    logic                         w_latch;
    logic                         w_decrement;
    logic                         w_vcFull;
    logic                         w_vcReady;
    logic                         w_payloadReady;
    logic [FLIT_DATA_WIDTH-1:0]   w_headFields;

    assign w_vcFull       = adjacent_node_vc_is_full[r_vc];
    assign w_vcReady      = adjacent_node_is_ready[r_vc];
    assign w_payloadReady = (r_state == PAYLOAD) && !w_vcFull;

    // Handshake outputs are held low while reset is asserted so the CPU never
    // sees a stale ready during reset.
    assign pkt_req_ready = (r_state == IDLE) && !reset;
    assign payload_ready = w_payloadReady && !reset;

    assign flit_data_output          = r_flit;
    assign flit_data_output_is_valid = r_flitValid;
    assign packet_sent               = r_packetSent;
    assign pkt_error                 = r_pktError;

    // Head payload: vc, destination and our own id, remaining low bits zero.
    always_comb begin
        w_headFields = '0;
        w_headFields[FLIT_DATA_WIDTH-1 -: HEAD_FIELDS_WIDTH] = {r_vc, r_dest, SOURCE_ID};
    end

    // Next-state and flit selection; one flit at most is decided per cycle.
    always_comb begin
        w_nextState  = r_state;
        w_emit       = 1'b0;
        w_flit       = '0;
        w_packetSent = 1'b0;
        w_pktError   = 1'b0;
        w_latch      = 1'b0;
        w_decrement  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (pkt_req_valid) begin
                    if ((pkt_dest == SOURCE_ID) || (pkt_num_body > MAX_LEN)) begin
                        w_pktError = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_nextState = HEAD;
                    end
                end
            end
            HEAD: begin
                if (w_vcReady && !w_vcFull) begin
                    w_emit = 1'b1;
                    if (r_remaining == '0) begin
                        w_flit       = {TYPE_SINGLE, w_headFields};
                        w_packetSent = 1'b1;
                        w_nextState  = IDLE;
                    end else begin
                        w_flit      = {TYPE_HEAD, w_headFields};
                        w_nextState = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (payload_valid && w_payloadReady) begin
                    w_emit = 1'b1;
                    if (r_remaining > ONE_LEN) begin
                        w_flit      = {TYPE_BODY, payload_data};
                        w_decrement = 1'b1;
                    end else begin
                        w_flit       = {TYPE_TAIL, payload_data};
                        w_packetSent = 1'b1;
                        w_nextState  = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Packet context and registered flit output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dest       <= '0;
            r_vc         <= '0;
            r_remaining  <= '0;
            r_flit       <= '0;
            r_flitValid  <= 1'b0;
            r_packetSent <= 1'b0;
            r_pktError   <= 1'b0;
        end else begin
            r_flit       <= w_flit;
            r_flitValid  <= w_emit;
            r_packetSent <= w_packetSent;
            r_pktError   <= w_pktError;
            if (w_latch) begin
                r_dest      <= pkt_dest;
                r_vc        <= pkt_vc;
                r_remaining <= pkt_num_body;
            end else if (w_decrement) begin
                r_remaining <= r_remaining - ONE_LEN;
            end
        end
    end

endmodule

// File: doc/spidergon_packetizer.md
Name: spidergon_packetizer

Overview:
- Network-interface transmitter between a node's local CPU and the injection side of a spidergon node.
- Accepts a packet request (destination, VC, body length) plus a stream of payload words.
- Serialises them into head, body and tail flits (header-only packets are a single flit), using the node's 2-bit flit-type encoding.
- Obeys ON/OFF flow control: per-VC ready and per-VC full from the downstream buffer.

Parameters:
- NUM_OF_NODES, 8, node count; DEST_NODE_WIDTH = $clog2(NUM_OF_NODES)
- FLIT_DATA_WIDTH, 16, payload bits per flit; FLIT_TOTAL_WIDTH = FLIT_DATA_WIDTH+2
- NUM_OF_VIRTUAL_CHANNELS, 2, VC count; VC_ID_WIDTH = $clog2(NUM_OF_VIRTUAL_CHANNELS)
- NODE_IDENTIFIER, 0, this node's id, inserted as the source field
- MAX_BODY_FLITS, 4, max payload words per packet; LEN_WIDTH = $clog2(MAX_BODY_FLITS+1)

Ports:
- clk  in  1  single clock, all logic posedge
- reset  in  1  synchronous, active-high
- pkt_req_valid  in  1  CPU presents a packet request
- pkt_req_ready  out  1  block is IDLE and can take a request
- pkt_dest  in  DEST_NODE_WIDTH  destination node
- pkt_vc  in  VC_ID_WIDTH  virtual channel for the whole packet
- pkt_num_body  in  LEN_WIDTH  payload word count; 0 = header-only packet
- payload_valid  in  1  payload word offered
- payload_data  in  FLIT_DATA_WIDTH  payload word
- payload_ready  out  1  payload word accepted this cycle when payload_valid is also high
- flit_data_output  out  FLIT_TOTAL_WIDTH  flit to node
- flit_data_output_is_valid  out  1  flit_data_output carries a flit this cycle
- adjacent_node_is_ready  in  NUM_OF_VIRTUAL_CHANNELS  per-VC: downstream accepts a new head
- adjacent_node_vc_is_full  in  NUM_OF_VIRTUAL_CHANNELS  per-VC backpressure
- packet_sent  out  1  one-cycle pulse when the last flit of a packet is emitted
- pkt_error  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Flit type bits [FTW-1:FTW-2]: 01 head, 10 body, 00 tail, 11 header-only.
- Head / header-only flit layout below the type bits, MSB-first: vc (VC_ID_WIDTH), dest (DEST_NODE_WIDTH), source=NODE_IDENTIFIER (DEST_NODE_WIDTH); remaining LSBs are 0.
- Body and tail flits carry payload_data in [FLIT_DATA_WIDTH-1:0].
- Reset: state=IDLE, all registers 0; flit_data_output=0, flit_data_output_is_valid=0, packet_sent=0, pkt_error=0. pkt_req_ready=0 and payload_ready=0 while reset is high.
- pkt_req_ready = (state==IDLE). payload_ready = (state==PAYLOAD) && !adjacent_node_vc_is_full[vc_q]. Both are combinational.
- State IDLE, on pkt_req_valid:
  - If pkt_dest==NODE_IDENTIFIER or pkt_num_body>MAX_BODY_FLITS: pulse pkt_error next cycle, stay IDLE, latch nothing.
  - Otherwise latch dest_q, vc_q, remaining=pkt_num_body and go to HEAD.
- State HEAD: permission = adjacent_node_is_ready[vc_q] && !adjacent_node_vc_is_full[vc_q]. When permission holds, emit the head flit:
  - remaining==0: type 11, packet_sent pulse, go to IDLE.
  - Otherwise: type 01, go to PAYLOAD.
- State PAYLOAD: on a payload handshake, emit a flit with payload_data:
  - remaining>1: type 10, decrement remaining.
  - remaining==1: type 00, packet_sent pulse, go to IDLE.
- Emission is registered, 1-cycle latency.
  - Flit decided in cycle t appears on flit_data_output with is_valid=1 in cycle t+1.
  - In non-emitting cycles is_valid=0 and flit_data_output=0.
  - packet_sent is aligned with the tail / header-only flit's valid cycle.
- Minimum timing: request accepted at t gives head valid at t+2. Back-to-back flits are possible every cycle while permission holds.
- vc_is_full rising mid-packet: no flit emitted and payload_ready=0 until it clears. No flit is dropped or duplicated, and no VC switch occurs mid-packet.
- adjacent_node_is_ready is ignored after the head flit; only full gates body and tail flits.
- pkt_req_valid outside IDLE is ignored (not queued).
- After a tail is emitted, the state is IDLE in the next cycle; the next request is accepted at the earliest then.
- Reset mid-packet: packet abandoned, no tail emitted, is_valid=0 the following cycle, state=IDLE.

Test Plan:
- Defaults, NODE_IDENTIFIER=2. Request dest=3 vc=0 num_body=0, downstream ready/not full -> one flit 0x33400 valid at t+2, packet_sent same cycle, then idle.
- Request dest=5 vc=1 num_body=2, payload 0xABCD then 0x1234 -> flits 0x1D400, 0x2ABCD, 0x01234 on consecutive cycles; packet_sent with 0x01234.
- Same packet with adjacent_node_vc_is_full[1]=1 for 3 cycles after the head -> payload_ready=0 and is_valid=0 for those 3 cycles; body and tail follow after full drops, values unchanged.
- Request vc=1 with adjacent_node_is_ready[1]=0 for 4 cycles -> no head emitted; head 0x1D400 appears 1 cycle after ready rises; ready on vc0 has no effect.
- Request dest=2 (self) or num_body=5 -> pkt_error pulse, no flit, pkt_req_ready stays 1.
- reset asserted after the head of a 3-word packet -> no further flits, all outputs 0, pkt_req_ready=1 the cycle after reset drops; a new header-only request then completes normally.
